// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I/D cache line arbiter onto a single physical memory port
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin conflict arbitration;
// default build uses fixed DATA-over-INST priority).

module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  // Transaction latched at grant time; held untouched until the next grant.
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic                    op_rd_q;
  logic                    op_wr_q;

  logic                    d_req;
  logic                    grant_i;
  logic                    grant_d;
  logic                    data_wins;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when DATA received the most recent grant; cleared means INST did.
  logic last_data_q;

  assign data_wins = ~last_data_q;

  // Remember the most recent grantee so a conflict alternates between caches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_data_q <= 1'b0;
    end else if (grant_d) begin
      last_data_q <= 1'b1;
    end else if (grant_i) begin
      last_data_q <= 1'b0;
    end
  end
`else
  assign data_wins = 1'b1;
`endif

  // Next-state and grant decode; only IDLE can grant a new transaction.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || data_wins)) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (i_read) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          state_d = RELEASE;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted request; a simultaneous read+write collapses to a write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      op_rd_q <= d_read & ~d_write;
      op_wr_q <= d_write;
    end else if (grant_i) begin
      addr_q  <= i_addr;
      op_rd_q <= 1'b1;
      op_wr_q <= 1'b0;
    end
  end

  // Memory strobes and cache responses are pure decodes of the owner state.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      I_BUSY: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp & reset;
      end
      D_BUSY: begin
        pmem_read  = op_rd_q;
        pmem_write = op_wr_q;
        d_resp     = pmem_resp & reset;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized scoreboard bench for cache_arbiter

module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_data;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            start;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   resp_en = 0;
  bit   active = 0;
  int   last_resp = -100;
  bit   last_data = 0;
  bit   abort = 0;
  exp_t cur;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = a ^ 32'hA5A5_A5A5;
    return {8{w}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: random latency, line content derived from the address.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (pmem_resp) begin
          pmem_resp = 1'b0;
          pmem_rdata = rand_line();
        end else if (pmem_read || pmem_write) begin
          if (wait_cnt == 0) begin
            pmem_resp = 1'b1;
            pmem_rdata = line_of(pmem_addr);
            wait_cnt = $urandom_range(0, 4);
          end else begin
            wait_cnt--;
            pmem_rdata = rand_line();
          end
        end else begin
          pmem_rdata = rand_line();
        end
      end
    end
  end

  // Monitor: pops the next expected transaction when a memory strobe appears.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("resp_overlap", i_resp & d_resp, 1'b0);
      if (!active && (pmem_read || pmem_write)) begin
        if (q.size() == 0) begin
          chk("unexpected_txn", pmem_read | pmem_write, 1'b0);
        end else begin
          cur = q.pop_front();
          active = 1;
          chk("txn_read", pmem_read, cur.rd);
          chk("txn_write", pmem_write, cur.wr);
          chk("txn_addr", pmem_addr, cur.addr);
          if (cur.wr) chk("txn_wdata", pmem_wdata, cur.wdata);
          if (cur.start >= 0) chk("txn_latency", cyc, cur.start);
          chk("txn_gap_ge3", (cyc - last_resp) >= 3, 1'b1);
        end
      end else if (active) begin
        chk("hold_strobes", {pmem_read, pmem_write}, {cur.rd, cur.wr});
        chk("hold_addr", pmem_addr, cur.addr);
        if (cur.wr) chk("hold_wdata", pmem_wdata, cur.wdata);
      end
      if (i_resp || d_resp) begin
        if (!active) begin
          chk("spurious_resp", {i_resp, d_resp}, 2'b00);
        end else begin
          chk("resp_owner", {i_resp, d_resp}, cur.is_data ? 2'b01 : 2'b10);
          if (cur.rd) chk("resp_rdata", cur.is_data ? d_rdata : i_rdata, cur.rdata);
          active = 0;
          last_resp = cyc;
        end
      end
    end
  end

  // One arbitration round: kind 1 = INST only, 2 = DATA only, 3 = both at once.
  task automatic run_round(input int kind_in);
    int kind, op, it;
    bit i_need, d_need, i_got, d_got, d_first;
    exp_t ei, ed;
    kind = (kind_in == 0) ? $urandom_range(1, 3) : kind_in;
    i_need = (kind != 2);
    d_need = (kind != 1);
    ei.is_data = 0; ei.rd = 1; ei.wr = 0;
    ei.addr = $urandom & ~32'h1F; ei.wdata = '0; ei.rdata = line_of(ei.addr);
    op = $urandom_range(0, 2);
    ed.is_data = 1;
    ed.wr = (op != 0);
    ed.rd = !ed.wr;
    ed.addr = $urandom & ~32'h1F; ed.wdata = rand_line(); ed.rdata = line_of(ed.addr);
`ifdef ARB_ROUND_ROBIN_EN
    d_first = d_need && (!i_need || !last_data);
`else
    d_first = d_need;
`endif
    ei.start = (i_need && !d_first) ? cyc + 1 : -1;
    ed.start = d_first ? cyc + 1 : -1;
    if (d_first) begin
      q.push_back(ed);
      if (i_need) q.push_back(ei);
    end else begin
      q.push_back(ei);
      if (d_need) q.push_back(ed);
    end
    last_data = (d_first && !i_need) || (!d_first && d_need);
    if (i_need) begin i_read = 1; i_addr = ei.addr; end
    else i_addr = $urandom;
    if (d_need) begin
      d_read = (op == 0 || op == 2); d_write = (op != 0);
      d_addr = ed.addr; d_wdata = ed.wdata;
    end
    i_got = 0; d_got = 0; it = 0;
    while (((i_need && !i_got) || (d_need && !d_got)) && it < 200) begin
      @(negedge clk);
      if (i_resp) i_got = 1;
      if (d_resp) d_got = 1;
      @(posedge clk);
      #1;
      it++;
      if (i_got) i_read = 0;
      if (d_got) begin d_read = 0; d_write = 0; end
      if (it == 2 && kind != 3) begin
        i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
        if ($urandom_range(0, 1) == 1) begin
          i_read = 0; d_read = 0; d_write = 0;
        end
      end
    end
    if (it >= 200) begin
      chk("round_timeout", {i_got, d_got}, {i_need, d_need});
      abort = 1;
    end
    i_read = 0; d_read = 0; d_write = 0;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    pmem_rdata = rand_line();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_addr", pmem_addr, '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_i_rdata", i_rdata, pmem_rdata);
    chk("rst_d_rdata", d_rdata, pmem_rdata);
    @(posedge clk);
    #1;
    reset = 1'b1;
    resp_en = 1; mon_en = 1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 40 && !abort; r++) run_round(r < 3 ? 3 : 0);

    if (!abort) begin
      mon_en = 0; resp_en = 0; pmem_resp = 1'b0;
      d_read = 0; d_write = 1; d_addr = 32'h0000_2000; d_wdata = {32{8'h5A}};
      repeat (3) @(posedge clk);
      #1;
      chk("busy_write", pmem_write, 1'b1);
      chk("busy_addr", pmem_addr, 32'h0000_2000);
      reset = 1'b0; d_write = 0;
      @(posedge clk);
      #1;
      chk("abort_strobes", {pmem_read, pmem_write}, 2'b00);
      chk("abort_addr", pmem_addr, '0);
      chk("abort_wdata", pmem_wdata, '0);
      chk("abort_resp", d_resp, 1'b0);
      reset = 1'b1;
      pmem_resp = 1'b1; pmem_rdata = rand_line();
      @(negedge clk);
      chk("late_resp_ignored", {i_resp, d_resp}, 2'b00);
      chk("late_resp_strobes", {pmem_read, pmem_write}, 2'b00);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      chk("post_abort_idle", {pmem_read, pmem_write}, 2'b00);
      @(posedge clk);
      #1;
      last_data = 0; last_resp = -100; active = 0;
      resp_en = 1; mon_en = 1;
      for (int r = 0; r < 3 && !abort; r++) run_round(3);
      for (int r = 0; r < 6 && !abort; r++) run_round(0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("no_open_txn", active, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
